// File: rtl/tx_frame_ctrl.sv
// Transmit frame sequencer: SOF, then each payload byte as four 2-bit PPM symbols (MSB first), then EOF.
// Every WAIT_* state is guarded by a TIMEOUT-cycle watchdog that aborts the frame with an err pulse.
module tx_frame_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       control_sof,
    input  logic       sof_done,
    output logic       sym_start,
    output logic [1:0] sym_data,
    input  logic       sym_done,
    output logic       control_eof,
    input  logic       eof_done,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    typedef enum logic [3:0] {
        IDLE, SOF, WAIT_SOF, FETCH, SYM, WAIT_SYM, EOF, WAIT_EOF, DONE
    } state_t;

    // A WAIT state gives up at the end of the cycle in which its counter reads TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] byte_q, byte_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] sym_data_q, sym_data_d;
    logic       byte_ready_q, control_sof_q, sym_start_q, control_eof_q;
    logic       busy_q, frame_done_q, err_q, err_d;
    logic       timed_out;
    logic       in_wait;

    function automatic logic [1:0] pick_sym(input logic [7:0] b, input logic [1:0] i);
        case (i)
            2'd0:    return b[7:6];
            2'd1:    return b[5:4];
            2'd2:    return b[3:2];
            default: return b[1:0];
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        byte_d      = byte_q;
        idx_d       = idx_q;
        sym_data_d  = sym_data_q;
        wait_cnt_d  = '0;
        err_d       = 1'b0;
        timed_out   = (wait_cnt_q == WAIT_LAST);
        in_wait     = (state_q == WAIT_SOF) || (state_q == WAIT_SYM) || (state_q == WAIT_EOF);

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = frame_len;
                    state_d     = SOF;
                end
            end
            SOF: state_d = WAIT_SOF;
            WAIT_SOF: begin
                if (sof_done) begin
                    state_d = (remaining_q != 8'd0) ? FETCH : EOF;
                end else if (timed_out) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            FETCH: begin
                if (byte_valid && byte_ready_q) begin
                    byte_d     = byte_data;
                    idx_d      = 2'd0;
                    sym_data_d = byte_data[7:6];
                    state_d    = SYM;
                end
            end
            SYM: state_d = WAIT_SYM;
            WAIT_SYM: begin
                if (sym_done) begin
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_q + 2'd1;
                        sym_data_d = pick_sym(byte_q, idx_q + 2'd1);
                        state_d    = SYM;
                    end else begin
                        remaining_d = remaining_q - 8'd1;
                        state_d     = (remaining_q == 8'd1) ? EOF : FETCH;
                    end
                end else if (timed_out) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            EOF: state_d = WAIT_EOF;
            WAIT_EOF: begin
                if (eof_done) begin
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The counter runs only while a WAIT state is held; any other state clears it.
        if (in_wait && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            byte_q        <= '0;
            idx_q         <= '0;
            wait_cnt_q    <= '0;
            sym_data_q    <= '0;
            byte_ready_q  <= 1'b0;
            control_sof_q <= 1'b0;
            sym_start_q   <= 1'b0;
            control_eof_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            byte_q        <= byte_d;
            idx_q         <= idx_d;
            wait_cnt_q    <= wait_cnt_d;
            sym_data_q    <= sym_data_d;
            byte_ready_q  <= (state_d == FETCH);
            control_sof_q <= (state_d == SOF);
            sym_start_q   <= (state_d == SYM);
            control_eof_q <= (state_d == EOF);
            busy_q        <= (state_d != IDLE);
            frame_done_q  <= (state_d == DONE);
            err_q         <= err_d;
        end
    end

    assign byte_ready  = byte_ready_q;
    assign control_sof = control_sof_q;
    assign sym_start   = sym_start_q;
    assign sym_data    = sym_data_q;
    assign control_eof = control_eof_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Bench for tx_frame_ctrl: an event-order model (SOF, symbols, EOF, DONE/ERR) plus per-cycle rules,
// driven by auto-responders for the *_done handshakes and a byte source with per-byte stalls.
module tb_tx_frame_ctrl;

    localparam int TO     = 10;
    localparam int EV_SOF = 100;
    localparam int EV_EOF = 101;
    localparam int EV_FD  = 102;
    localparam int EV_ERR = 103;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       sof_done_r = 1'b0, sym_done_r = 1'b0, eof_done_r = 1'b0, sym_done_inj = 1'b0;
    logic       sof_done, sym_done, eof_done;
    logic       byte_ready, control_sof, sym_start, control_eof, busy, frame_done, err;
    logic [1:0] sym_data;

    assign sof_done = sof_done_r;
    assign sym_done = sym_done_r | sym_done_inj;
    assign eof_done = eof_done_r;

    tx_frame_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .control_sof(control_sof), .sof_done(sof_done),
        .sym_start(sym_start), .sym_data(sym_data), .sym_done(sym_done),
        .control_eof(control_eof), .eof_done(eof_done),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model state ----------------
    int   exp_q[$];
    int   sym_log[$];
    int   bytes_left = 0;
    int   br_cnt = 0;
    int   sof_cyc = 0, sym_cyc = 0, eof_cyc = 0, fd_cyc = 0, err_cyc = 0;
    int   gen = 0;
    int   sof_dly = 0, sym_dly = 0, eof_dly = 0;
    bit   sym_en = 1'b1;

    typedef struct { logic [7:0] d; int stall; } src_t;
    src_t src_q[$];
    int   stall_left = 0;

    task automatic got(input int ev, input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: event %0d arrived, none expected", name, ev);
        end else begin
            int e;
            e = exp_q.pop_front();
            if (e != ev) begin
                errors++;
                $display("FAIL %s: event %0d arrived, expected %0d", name, ev, e);
            end
        end
    endtask

    // ---------------- done responders ----------------
    function automatic bit trig(input int w);
        case (w)
            0:       return control_sof;
            1:       return sym_start;
            default: return control_eof;
        endcase
    endfunction

    function automatic int dly(input int w);
        case (w)
            0:       return sof_dly;
            1:       return sym_dly;
            default: return eof_dly;
        endcase
    endfunction

    task automatic drive_done(input int w, input logic v);
        case (w)
            0:       sof_done_r = v;
            1:       sym_done_r = v;
            default: eof_done_r = v;
        endcase
    endtask

    // Done is raised in wait cycle number dly (0 = first cycle of the WAIT state).
    task automatic responder(input int w);
        bit skip;
        int g;
        skip = 1'b0;
        forever begin
            if (!skip) begin
                @(posedge clk);
                #1;
            end
            skip = 1'b0;
            if (rst_n && trig(w) && (w != 1 || sym_en)) begin
                g = gen;
                repeat (1 + dly(w)) @(posedge clk);
                #1;
                if (g == gen) begin
                    drive_done(w, 1'b1);
                    @(posedge clk);
                    #1;
                    drive_done(w, 1'b0);
                    skip = 1'b1;
                end
            end
        end
    endtask

    initial responder(0);
    initial responder(1);
    initial responder(2);

    // ---------------- byte source (stall counts only cycles with byte_ready high) ----------------
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = byte_valid && byte_ready && rst_n;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) begin
                src_q.delete(0);
                if (src_q.size() > 0) stall_left = src_q[0].stall;
            end
            if (src_q.size() > 0 && stall_left > 0 && byte_ready) stall_left--;
            byte_valid = (src_q.size() > 0 && stall_left == 0);
            byte_data  = (src_q.size() > 0) ? src_q[0].d : 8'h00;
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic [4:0] pulses, prev;
        logic [1:0] hold;
        bit         win, inf, cur;
        prev = '0; hold = '0; win = 1'b0; inf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_outputs", int'({byte_ready, control_sof, sym_start, control_eof,
                                          busy, frame_done, err, sym_data}), 0);
                prev = '0;
                win  = 1'b0;
                inf  = 1'b0;
            end else begin
                pulses = {control_sof, sym_start, control_eof, frame_done, err};
                chk("pulse_width", int'(pulses & prev), 0);
                prev = pulses;
                if (control_sof) begin sof_cyc = cyc; got(EV_SOF, "sof_event"); end
                if (sym_start) begin
                    sym_cyc = cyc;
                    sym_log.push_back(int'(sym_data));
                    got(int'(sym_data), "symbol_event");
                    hold = sym_data;
                    win  = 1'b1;
                end else if (win) begin
                    chk("sym_data_stable", int'(sym_data), int'(hold));
                end
                if (win && sym_done) win = 1'b0;
                if (control_eof) begin eof_cyc = cyc; got(EV_EOF, "eof_event"); end
                if (frame_done) begin fd_cyc = cyc; got(EV_FD, "frame_done_event"); end
                if (err) begin err_cyc = cyc; got(EV_ERR, "err_event"); end
                cur = control_sof || (inf && !err);
                chk("busy", int'(busy), int'(cur));
                inf = cur && !frame_done;
                chk("byte_ready_allowed", int'(byte_ready && bytes_left == 0), 0);
                if (byte_ready) br_cnt++;
                if (byte_ready && byte_valid) bytes_left--;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+2) ----------------
    task automatic push_byte(input logic [7:0] d, input int stall);
        src_t e;
        e.d = d;
        e.stall = stall;
        if (src_q.size() == 0) stall_left = stall;
        src_q.push_back(e);
        exp_q.push_back(int'(d[7:6]));
        exp_q.push_back(int'(d[5:4]));
        exp_q.push_back(int'(d[3:2]));
        exp_q.push_back(int'(d[1:0]));
    endtask

    task automatic start_frame(input int len);
        bytes_left = len;
        sym_log.delete();
        br_cnt = 0;
        start = 1'b1;
        frame_len = 8'(len);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_sym_data", int'(sym_data), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // frame_len=1, byte 0xB4, prompt dones
        exp_q.push_back(EV_SOF);
        push_byte(8'hB4, 0);
        exp_q.push_back(EV_EOF);
        exp_q.push_back(EV_FD);
        start_frame(1);
        wait_idle(100, "b4_frame_complete");
        chk("b4_nsym", sym_log.size(), 4);
        if (sym_log.size() == 4) begin
            chk("b4_sym0", sym_log[0], 2);
            chk("b4_sym1", sym_log[1], 3);
            chk("b4_sym2", sym_log[2], 1);
            chk("b4_sym3", sym_log[3], 0);
        end
        chk("b4_sof_to_done", fd_cyc - sof_cyc, 13);

        // frame_len=0
        exp_q.push_back(EV_SOF);
        exp_q.push_back(EV_EOF);
        exp_q.push_back(EV_FD);
        start_frame(0);
        wait_idle(100, "len0_frame_complete");
        chk("len0_byte_ready_cycles", br_cnt, 0);
        chk("len0_sof_to_eof", eof_cyc - sof_cyc, 2);

        // sym_done withheld -> timeout abort
        sym_en = 1'b0;
        exp_q.push_back(EV_SOF);
        src_q.push_back('{d: 8'h1B, stall: 0});
        stall_left = 0;
        exp_q.push_back(0);
        exp_q.push_back(EV_ERR);
        start_frame(1);
        wait_idle(100, "timeout_sequence");
        chk("timeout_sym_to_err", err_cyc - sym_cyc, 11);
        chk("timeout_busy_after", int'(busy), 0);
        sym_en = 1'b1;

        // frame_len=3 with a 50-cycle source stall before byte 2
        exp_q.push_back(EV_SOF);
        push_byte(8'h1B, 0);
        push_byte(8'hE4, 50);
        push_byte(8'h96, 0);
        exp_q.push_back(EV_EOF);
        exp_q.push_back(EV_FD);
        start_frame(3);
        wait_idle(400, "len3_frame_complete");
        chk("len3_nsym", sym_log.size(), 12);
        if (sym_log.size() == 12) begin
            chk("len3_sym4", sym_log[4], 3);
            chk("len3_sym11", sym_log[11], 2);
        end

        // done arriving in the last allowed wait cycle wins over timeout
        sof_dly = TO - 1;
        exp_q.push_back(EV_SOF);
        push_byte(8'h5A, 0);
        exp_q.push_back(EV_EOF);
        exp_q.push_back(EV_FD);
        start_frame(1);
        wait_idle(100, "late_done_frame");
        chk("late_done_sof_to_done", fd_cyc - sof_cyc, 13 + TO - 1);
        sof_dly = 0;

        // eof_done one cycle too late -> abort after EOF
        eof_dly = TO;
        exp_q.push_back(EV_SOF);
        push_byte(8'h5A, 0);
        exp_q.push_back(EV_EOF);
        exp_q.push_back(EV_ERR);
        start_frame(1);
        wait_idle(100, "eof_timeout_sequence");
        chk("eof_to_err", err_cyc - eof_cyc, 11);
        repeat (4) @(posedge clk);
        #2;
        eof_dly = 0;

        // start while busy and sym_done in WAIT_SOF are ignored
        sof_dly = 4;
        exp_q.push_back(EV_SOF);
        push_byte(8'h27, 0);
        exp_q.push_back(EV_EOF);
        exp_q.push_back(EV_FD);
        start_frame(1);
        @(posedge clk);
        #2;
        start = 1'b1;
        frame_len = 8'd5;
        sym_done_inj = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        sym_done_inj = 1'b0;
        wait_idle(100, "ignore_frame_complete");
        chk("ignore_sof_to_done", fd_cyc - sof_cyc, 17);
        sof_dly = 0;

        // reset during WAIT_SYM of byte 2, then a clean frame
        sym_dly = 6;
        exp_q.push_back(EV_SOF);
        push_byte(8'h1B, 0);
        push_byte(8'hC3, 0);
        exp_q.push_back(EV_EOF);
        exp_q.push_back(EV_FD);
        start_frame(2);
        begin
            int n;
            n = 0;
            while (sym_log.size() < 5 && n < 200) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        chk("reached_byte2", sym_log.size(), 5);
        #1;
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_sym_data", int'(sym_data), 3);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({byte_ready, control_sof, sym_start, control_eof,
                                        busy, frame_done, err, sym_data}), 0);
        exp_q.delete();
        src_q.delete();
        gen++;
        bytes_left = 0;
        sym_dly = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk("no_resume_busy", int'(busy), 0);
        exp_q.push_back(EV_SOF);
        push_byte(8'hB4, 0);
        exp_q.push_back(EV_EOF);
        exp_q.push_back(EV_FD);
        start_frame(1);
        wait_idle(100, "post_reset_frame");
        chk("post_reset_sof_to_done", fd_cyc - sof_cyc, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
